axis_m_pkt: RTL and testbench



---
 rtl/axis_m_pkt.sv | 133 +++++++++++++
 tb/tb_axis_m_pkt.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_m_pkt.sv
// AXI-Stream master: local FIFO feeding a framed packet of pkt_len+1 beats with tlast/finish.
// Optional tkeep/last_keep ports are enabled by defining AXIS_M_TKEEP_EN.
module axis_m_pkt #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned LEN_W      = 8
) (
  input  logic                        aclk,
  input  logic                        areset_n,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       push_data,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow,
  input  logic                        start,
  input  logic [LEN_W-1:0]            pkt_len,
  output logic                        busy,
  input  logic                        tready,
  output logic                        tvalid,
  output logic [DATA_WIDTH-1:0]       tdata,
  output logic                        tlast,
`ifdef AXIS_M_TKEEP_EN
  output logic [DATA_WIDTH/8-1:0]     tkeep,
  input  logic [DATA_WIDTH/8-1:0]     last_keep,
`endif
  output logic                        finish
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  empty;
  logic                  push_ok;
  logic                  load;
  logic                  hs;
  logic [LEN_W-1:0]      rem;
  logic [LEN_W-1:0]      beats;
  logic                  issued_all;
  logic                  is_final;
`ifdef AXIS_M_TKEEP_EN
  logic [DATA_WIDTH/8-1:0] keep_lat;
`endif

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign push_ok  = push & ~full;
  assign hs       = tvalid & tready;
  assign is_final = (beats == rem);
  assign busy     = (state == SEND);
  // The beat counter wraps for a 2^LEN_W-beat packet, so a flag marks the final issue.
  assign load     = (state == SEND) && !issued_all && !empty && (!tvalid || tready);

  always_ff @(posedge aclk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (load)    rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, load})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (push && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= IDLE;
      rem        <= '0;
      beats      <= '0;
      issued_all <= 1'b0;
      tvalid     <= 1'b0;
      tdata      <= '0;
      tlast      <= 1'b0;
      finish     <= 1'b0;
`ifdef AXIS_M_TKEEP_EN
      tkeep      <= '1;
      keep_lat   <= '1;
`endif
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem        <= pkt_len;
            beats      <= '0;
            issued_all <= 1'b0;
`ifdef AXIS_M_TKEEP_EN
            keep_lat   <= last_keep;
`endif
            state      <= SEND;
          end
        end
        SEND: begin
          if (hs && tlast) begin
            state  <= IDLE;
            finish <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        tdata  <= mem[rd_ptr];
        tvalid <= 1'b1;
        tlast  <= is_final;
        beats  <= beats + 1'b1;
        if (is_final) issued_all <= 1'b1;
`ifdef AXIS_M_TKEEP_EN
        tkeep  <= is_final ? keep_lat : '1;
`endif
      end else if (hs) begin
        tvalid <= 1'b0;
        tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_m_pkt.sv
// Scoreboard bench for axis_m_pkt: stimulus queues expected beats, a monitor pops on each handshake.
module tb_axis_m_pkt;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int LW = 8;

  logic          aclk = 1'b0;
  logic          areset_n = 1'b0;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          full;
  logic [4:0]    level;
  logic          overflow;
  logic          start = 1'b0;
  logic [LW-1:0] pkt_len = '0;
  logic          busy;
  logic          tready = 1'b0;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          finish;
`ifdef AXIS_M_TKEEP_EN
  logic [3:0]    tkeep;
  logic [3:0]    last_keep = 4'hF;
`endif

  axis_m_pkt #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_W(LW)) dut (
    .aclk(aclk), .areset_n(areset_n), .push(push), .push_data(push_data),
    .full(full), .level(level), .overflow(overflow), .start(start),
    .pkt_len(pkt_len), .busy(busy), .tready(tready), .tvalid(tvalid),
    .tdata(tdata), .tlast(tlast),
`ifdef AXIS_M_TKEEP_EN
    .tkeep(tkeep), .last_keep(last_keep),
`endif
    .finish(finish)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic [3:0]    k;
  } beat_t;

  beat_t   sb[$];
  int      checks = 0;
  int      errors = 0;
  int      fin_cnt = 0;
  int      exp_fin = 0;
  logic    stall_prev = 1'b0;
  logic [DW-1:0] stall_d;
  logic    stall_l;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sample away from the rising edge; values here are what the next edge sees.
  always @(negedge aclk) begin
    if (areset_n) begin
      if (finish) fin_cnt++;
      if (stall_prev) begin
        chk("hold_valid", 64'(tvalid), 64'd1);
        chk("hold_data", 64'(tdata), 64'(stall_d));
        chk("hold_last", 64'(tlast), 64'(stall_l));
      end
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h with empty scoreboard", tdata);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_data", 64'(tdata), 64'(e.d));
          chk("beat_last", 64'(tlast), 64'(e.l));
`ifdef AXIS_M_TKEEP_EN
          chk("beat_keep", 64'(tkeep), 64'(e.k));
`endif
        end
      end
      stall_prev = tvalid && !tready;
      stall_d    = tdata;
      stall_l    = tlast;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    push = 1'b1;
    push_data = d;
    cyc();
    push = 1'b0;
  endtask

  task automatic expect_beat(input logic [DW-1:0] d, input logic l, input logic [3:0] k);
    beat_t e;
    e.d = d; e.l = l; e.k = k;
    sb.push_back(e);
  endtask

  task automatic start_pkt(input logic [LW-1:0] len);
    start = 1'b1;
    pkt_len = len;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      cyc();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles", name, budget);
    end
    cyc();
  endtask

  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int n;
    // Reset values
    #2;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_finish", 64'(finish), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
`ifdef AXIS_M_TKEEP_EN
    chk("rst_tkeep", 64'(tkeep), 64'hF);
`endif
    cyc();
    areset_n = 1'b1;
    cyc();

    // Back-to-back packet, tready held high
    tready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(DW'(32'hA0 + i));
    chk("t1_level4", 64'(level), 64'd4);
    for (int i = 0; i < 4; i++) expect_beat(DW'(32'hA0 + i), i == 3, 4'hF);
    start_pkt(8'd3);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_idle("t1", 40, n);
    chk("t1_cycles", 64'(n), 64'd5);
    exp_fin++;
    chk("t1_finish", 64'(fin_cnt), 64'(exp_fin));
    chk("t1_level0", 64'(level), 64'd0);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure pattern 1,0,0,1
    for (int i = 0; i < 4; i++) push_word(DW'(32'hB0 + i));
    for (int i = 0; i < 4; i++) expect_beat(DW'(32'hB0 + i), i == 3, 4'hF);
    start_pkt(8'd3);
    n = 0;
    while (busy && n < 60) begin
      tready = pat[n % 4];
      cyc();
      n++;
    end
    chk("t2_done", 64'(busy), 64'd0);
    tready = 1'b1;
    cyc();
    exp_fin++;
    chk("t2_finish", 64'(fin_cnt), 64'(exp_fin));
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    // Start on empty FIFO, data trickles in
    expect_beat(DW'(32'h11), 1'b0, 4'hF);
    expect_beat(DW'(32'h22), 1'b0, 4'hF);
    expect_beat(DW'(32'h33), 1'b1, 4'hF);
    start_pkt(8'd2);
    push_word(DW'(32'h11));
    cyc(); cyc(); cyc();
    chk("t3_gap_tvalid", 64'(tvalid), 64'd0);
    chk("t3_gap_busy", 64'(busy), 64'd1);
    push_word(DW'(32'h22));
    push_word(DW'(32'h33));
    wait_idle("t3", 40, n);
    exp_fin++;
    chk("t3_finish", 64'(fin_cnt), 64'(exp_fin));
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);

    // Overfill by one, then drain 16 beats
    for (int i = 0; i <= DEPTH; i++) push_word(DW'(32'hC0 + i));
    chk("t4_full", 64'(full), 64'd1);
    chk("t4_level", 64'(level), 64'd16);
    chk("t4_overflow", 64'(overflow), 64'd1);
    for (int i = 0; i < DEPTH; i++) expect_beat(DW'(32'hC0 + i), i == DEPTH - 1, 4'hF);
    start_pkt(8'd15);
    wait_idle("t4", 80, n);
    exp_fin++;
    chk("t4_finish", 64'(fin_cnt), 64'(exp_fin));
    chk("t4_level0", 64'(level), 64'd0);
    chk("t4_notfull", 64'(full), 64'd0);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Reset during beat 2 of 4
    for (int i = 0; i < 4; i++) push_word(DW'(32'hD0 + i));
    expect_beat(DW'(32'hD0), 1'b0, 4'hF);
    start_pkt(8'd3);
    cyc();
    cyc();
    chk("t5_beat2_valid", 64'(tvalid), 64'd1);
    chk("t5_beat2_data", 64'(tdata), 64'hD1);
    areset_n = 1'b0;
    #1;
    chk("t5_rst_tvalid", 64'(tvalid), 64'd0);
    chk("t5_rst_tlast", 64'(tlast), 64'd0);
    chk("t5_rst_finish", 64'(finish), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_level", 64'(level), 64'd0);
    chk("t5_rst_overflow", 64'(overflow), 64'd0);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);
    cyc();
    areset_n = 1'b1;
    cyc();
    push_word(DW'(32'hE0));
    push_word(DW'(32'hE1));
    expect_beat(DW'(32'hE0), 1'b0, 4'hF);
    expect_beat(DW'(32'hE1), 1'b1, 4'hF);
    start_pkt(8'd1);
    wait_idle("t5", 40, n);
    exp_fin++;
    chk("t5_finish", 64'(fin_cnt), 64'(exp_fin));
    chk("t5_sb_done", 64'(sb.size()), 64'd0);

    // Single-beat packet
    push_word(DW'(32'hF5));
    expect_beat(DW'(32'hF5), 1'b1, 4'hF);
    start_pkt(8'd0);
    wait_idle("t6", 40, n);
    exp_fin++;
    chk("t6_finish", 64'(fin_cnt), 64'(exp_fin));
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

`ifdef AXIS_M_TKEEP_EN
    push_word(DW'(32'h55));
    push_word(DW'(32'h66));
    last_keep = 4'b0011;
    expect_beat(DW'(32'h55), 1'b0, 4'b1111);
    expect_beat(DW'(32'h66), 1'b1, 4'b0011);
    start_pkt(8'd1);
    last_keep = 4'b1111;
    wait_idle("t7", 40, n);
    exp_fin++;
    chk("t7_finish", 64'(fin_cnt), 64'(exp_fin));
    chk("t7_sb_empty", 64'(sb.size()), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
